// File: rtl/mult_scheduler_pkg.sv
// Shared definitions for the multiplier scheduler: widths, default wait and FSM encoding.
package mult_scheduler_pkg;

  localparam int unsigned MULT_WIDTH      = 8;
  localparam int unsigned DEF_WAIT_CYCLES = 1;
  localparam int unsigned CNT_WIDTH       = 4;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: with both requesting, the one not served last wins.
module rr_arbiter2 (
  input  logic REQ0,
  input  logic REQ1,
  input  logic LAST,
  output logic PICK_VALID,
  output logic PICK
);

  assign PICK_VALID = REQ0 | REQ1;
  assign PICK       = (REQ0 && REQ1) ? ~LAST : REQ1;

endmodule

// File: rtl/mult_scheduler.sv
// Time-shares one combinational 8-bit multiplier between two requesters, round-robin,
// with a fixed settle wait before capturing the product.
module mult_scheduler
  import mult_scheduler_pkg::*;
#(
  parameter int unsigned WIDTH       = MULT_WIDTH,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ0,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  output logic [WIDTH-1:0] MULTIPLICAND,
  output logic [WIDTH-1:0] MULTIPLIER,
  input  logic [WIDTH-1:0] PRODUCT,
  output logic [WIDTH-1:0] RESULT,
  output logic             GRANT0,
  output logic             GRANT1,
  output logic             DONE0,
  output logic             DONE1,
  output logic             BUSY
);

  state_e               r_state, w_state_d;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_d;
  logic [WIDTH-1:0]     r_mcand, w_mcand_d;
  logic [WIDTH-1:0]     r_mplier, w_mplier_d;
  logic [WIDTH-1:0]     r_result, w_result_d;
  logic                 r_grant0, w_grant0_d;
  logic                 r_grant1, w_grant1_d;
  logic                 r_done0, w_done0_d;
  logic                 r_done1, w_done1_d;
  logic                 r_last, w_last_d;

  logic w_pick_valid;
  logic w_pick;

  rr_arbiter2 u_arb (
    .REQ0       (REQ0),
    .REQ1       (REQ1),
    .LAST       (r_last),
    .PICK_VALID (w_pick_valid),
    .PICK       (w_pick)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_result <= '0;
      r_grant0 <= 1'b0;
      r_grant1 <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_last   <= 1'b1;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_mcand  <= w_mcand_d;
      r_mplier <= w_mplier_d;
      r_result <= w_result_d;
      r_grant0 <= w_grant0_d;
      r_grant1 <= w_grant1_d;
      r_done0  <= w_done0_d;
      r_done1  <= w_done1_d;
      r_last   <= w_last_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_mcand_d  = r_mcand;
    w_mplier_d = r_mplier;
    w_result_d = r_result;
    w_grant0_d = r_grant0;
    w_grant1_d = r_grant1;
    w_done0_d  = r_done0;
    w_done1_d  = r_done1;
    w_last_d   = r_last;

    case (r_state)
      StIdle: begin
        if (w_pick_valid) begin
          w_state_d  = StWait;
          w_mcand_d  = w_pick ? A1 : A0;
          w_mplier_d = w_pick ? B1 : B0;
          w_grant0_d = ~w_pick;
          w_grant1_d = w_pick;
          w_last_d   = w_pick;
          w_cnt_d    = CNT_WIDTH'(WAIT_CYCLES);
        end
      end
      StWait: begin
        w_cnt_d = r_cnt - 1'b1;
        // <= 1 rather than == 1 so a corrupted zero count cannot stall the FSM.
        if (r_cnt <= CNT_WIDTH'(1)) begin
          w_result_d = PRODUCT;
          w_done0_d  = r_grant0;
          w_done1_d  = r_grant1;
          w_state_d  = StDone;
        end
      end
      StDone: begin
        w_done0_d  = 1'b0;
        w_done1_d  = 1'b0;
        w_grant0_d = 1'b0;
        w_grant1_d = 1'b0;
        w_state_d  = StIdle;
      end
      default: begin
        w_done0_d  = 1'b0;
        w_done1_d  = 1'b0;
        w_grant0_d = 1'b0;
        w_grant1_d = 1'b0;
        w_state_d  = StIdle;
      end
    endcase
  end

  assign MULTIPLICAND = r_mcand;
  assign MULTIPLIER   = r_mplier;
  assign RESULT       = r_result;
  assign GRANT0       = r_grant0;
  assign GRANT1       = r_grant1;
  assign DONE0        = r_done0;
  assign DONE1        = r_done1;
  assign BUSY         = r_grant0 | r_grant1;

endmodule
